// File: rtl/peri_uart_pkg.sv
// peri_uart_pkg: register offsets, STATUS bit positions and TX FSM encoding
// shared by the UART transmitter and its FIFO neighbours.
package peri_uart_pkg;
    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_STATUS  = 4'h4;
    localparam logic [3:0] UART_BAUDDIV = 4'h8;
    localparam logic [3:0] UART_IRQEN   = 4'hC;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/peri_sync_fifo.sv
// peri_sync_fifo: single-clock FIFO with extra-MSB pointers; a push into a full
// FIFO is accepted only when a pop frees a slot on the same edge.
module peri_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    logic wr_en, rd_en;
    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout  = mem_q[rp_q[AW-1:0]];
    always_comb begin
        rd_en = pop & ~empty;
        wr_en = push & (~full | rd_en);
        wp_d  = wp_q + {{AW{1'b0}}, wr_en};
        rp_d  = rp_q + {{AW{1'b0}}, rd_en};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wp_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/peri_uart_tx.sv
// peri_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO,
// programmable bit time (BAUDDIV+1 clocks) and an idle/empty interrupt.
module peri_uart_tx
    import peri_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        regw,
    input  logic        regr,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdat,
    output logic        txd,
    output logic        irq
);
    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d, fifo_dout;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [15:0] baud_q, baud_d, bauddiv_q, bauddiv_d;
    logic [31:0] rdat_q, rdat_d, status, rd_mux;
    logic ack_q, ack_d, irq_q, irq_d, ovf_q, ovf_d, irqen_q, irqen_d;
    logic sel, wr, push, pop, full, empty, busy, bit_end;
    logic [3:0] off;
    logic unused;
    assign unused = ^{adr[1:0], wdata[31:16]};
    peri_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(cpurst), .push(push), .pop(pop), .din(wdata[7:0]),
        .dout(fifo_dout), .full(full), .empty(empty)
    );
    // Bus side: ack low for the cycle after each completion splits held requests.
    always_comb begin
        off    = {adr[3:2], 2'b00};
        sel    = (regw | regr) & (adr[31:4] == BASE_ADDR[31:4]) & ~ack_q;
        wr     = sel & regw;
        push   = wr & (off == UART_TXDATA);
        busy   = state_q != IDLE;
        status = '0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = ovf_q;
        rd_mux = off == UART_TXDATA  ? {31'b0, full} :
                 off == UART_STATUS  ? status :
                 off == UART_BAUDDIV ? {16'b0, bauddiv_q} : {31'b0, irqen_q};
        ack_d     = sel;
        rdat_d    = (sel & regr) ? rd_mux : '0;
        bauddiv_d = (wr & (off == UART_BAUDDIV)) ? wdata[15:0] : bauddiv_q;
        irqen_d   = (wr & (off == UART_IRQEN)) ? wdata[0] : irqen_q;
        ovf_d     = (push & full & ~pop) |
                    (ovf_q & ~(wr & (off == UART_STATUS) & wdata[ST_OVF]));
        irq_d     = irqen_q & empty & ~busy;
    end
    always_comb begin
        bit_end  = baud_q == '0;
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        baud_d   = bit_end ? bauddiv_q : baud_q - 16'd1;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                pop      = ~empty;
                baud_d   = bauddiv_q;
                bitcnt_d = '0;
                if (~empty) begin
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shift_d  = shift_q >> 1;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) state_d = STOP;
            end
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        txd = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    end
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            shift_q   <= '0;
            bitcnt_q  <= '0;
            baud_q    <= '0;
            bauddiv_q <= DEFAULT_DIV;
            irqen_q   <= 1'b0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            baud_q    <= baud_d;
            bauddiv_q <= bauddiv_d;
            irqen_q   <= irqen_d;
            ovf_q     <= ovf_d;
            ack_q     <= ack_d;
            rdat_q    <= rdat_d;
            irq_q     <= irq_d;
        end
    end
    assign ack  = ack_q;
    assign rdat = rdat_q;
    assign irq  = irq_q;
endmodule

// File: tb/tb_peri_uart_tx.sv
// tb_peri_uart_tx: directed register vectors plus hand-timed serial frames,
// baud change, overflow, interrupt, async reset and address-window cases.
module tb_peri_uart_tx;
    import peri_uart_pkg::*;
    localparam logic [31:0] BASE = 32'h4000_1000;
    logic clk = 1'b0, cpurst = 1'b1, regw = 1'b0, regr = 1'b0;
    logic [31:0] adr = '0, wdata = '0, rdat;
    logic ack, txd, irq;
    int n_cmp = 0, n_bad = 0;
    typedef struct {
        logic        w;
        logic [3:0]  off;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [14];

    peri_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
        .clk(clk), .cpurst(cpurst), .regw(regw), .regr(regr), .adr(adr),
        .wdata(wdata), .ack(ack), .rdat(rdat), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_wave(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output int lat);
        adr = a; wdata = d; regw = w; regr = ~w; lat = 0;
        do begin
            tick();
            lat++;
        end while (!ack && lat < 10);
        r = rdat;
        if (!ack) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_timeout: no ack at %h within %0d cycles", a, lat);
        end
        regw = 1'b0; regr = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] r;
        int lat;
        bus(1'b1, BASE + {28'b0, off}, d, r, lat);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] r;
        int lat;
        bus(1'b0, BASE + {28'b0, off}, 32'h0, r, lat);
        check(name, r, exp);
    endtask

    task automatic sample(input int n, output logic [127:0] w);
        w = '1;
        for (int i = 0; i < n; i++) begin
            tick();
            w[i] = txd;
        end
    endtask

    // Frame bit k (0 start, 1..8 data LSB first, 9 stop) lasts d0 clocks up to index chg, d1 after.
    function automatic logic [127:0] mkwave(input logic [7:0] b, input int chg, input int d0, input int d1);
        logic [127:0] w = '1;
        int p = 0;
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < ((k <= chg) ? d0 : d1); c++) begin
                w[p] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                p++;
            end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [127:0] wave;
        int lat, k, hits;
        vecs[0]  = '{1'b0, UART_STATUS,  32'h0,         32'h2};
        vecs[1]  = '{1'b0, UART_TXDATA,  32'h0,         32'h0};
        vecs[2]  = '{1'b0, UART_BAUDDIV, 32'h0,         32'h363};
        vecs[3]  = '{1'b0, UART_IRQEN,   32'h0,         32'h0};
        vecs[4]  = '{1'b1, UART_BAUDDIV, 32'hFFFF_1234, 32'h0};
        vecs[5]  = '{1'b0, UART_BAUDDIV, 32'h0,         32'h1234};
        vecs[6]  = '{1'b1, UART_IRQEN,   32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b0, UART_IRQEN,   32'h0,         32'h1};
        vecs[8]  = '{1'b1, UART_IRQEN,   32'hFFFF_FFFE, 32'h0};
        vecs[9]  = '{1'b0, UART_IRQEN,   32'h0,         32'h0};
        vecs[10] = '{1'b1, UART_STATUS,  32'h0000_00F7, 32'h0};
        vecs[11] = '{1'b0, UART_STATUS,  32'h0,         32'h2};
        vecs[12] = '{1'b1, UART_BAUDDIV, 32'h0000_0003, 32'h0};
        vecs[13] = '{1'b0, UART_BAUDDIV, 32'h0,         32'h3};

        repeat (3) tick();
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_rdat", rdat, 32'h0);
        check("rst_txd", {31'b0, txd}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h0);
        cpurst = 1'b0;
        tick();

        bus(1'b0, BASE + 32'h4, 32'h0, r, lat);
        check("first_rd_latency", lat, 1);
        check("first_rd_status", r, 32'h2);
        tick();
        check("rdat_zero_no_ack", rdat, 32'h0);
        check("idle_txd", {31'b0, txd}, 32'h1);
        check("idle_irq", {31'b0, irq}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            bus(vecs[i].w, BASE + {28'b0, vecs[i].off}, vecs[i].data, r, lat);
            if (!vecs[i].w) check($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // A5 at 4 clocks per bit, then four idle samples.
        wr(UART_TXDATA, 32'hA5);
        sample(44, wave);
        check_wave("frame_a5", wave, mkwave(8'hA5, 9, 4, 4));
        rd_chk("status_after_frame", UART_STATUS, 32'h2);

        // BAUDDIV 3 -> 1 lands inside data bit 2 (frame index 3).
        wr(UART_TXDATA, 32'h55);
        fork
            sample(32, wave);
            begin
                repeat (13) tick();
                wr(UART_BAUDDIV, 32'h1);
            end
        join
        check_wave("frame_baud_change", wave, mkwave(8'h55, 3, 4, 2));

        wr(UART_BAUDDIV, 32'd1000);
        for (int i = 0; i < 9; i++) wr(UART_TXDATA, i);
        rd_chk("status_full", UART_STATUS, 32'h5);
        wr(UART_TXDATA, 32'h9);
        rd_chk("status_ovf", UART_STATUS, 32'hD);
        rd_chk("txdata_full", UART_TXDATA, 32'h1);
        wr(UART_STATUS, 32'h8);
        rd_chk("status_ovf_clr", UART_STATUS, 32'h5);

        // Byte 0x00 is in data bit 0 after the 1001-clock start bit.
        repeat (1100) tick();
        check("pre_rst_txd", {31'b0, txd}, 32'h0);
        #2 cpurst = 1'b1;
        #1;
        check("async_rst_txd", {31'b0, txd}, 32'h1);
        check("async_rst_ack", {31'b0, ack}, 32'h0);
        check("async_rst_rdat", rdat, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        tick();
        tick();
        cpurst = 1'b0;
        tick();
        rd_chk("post_rst_status", UART_STATUS, 32'h2);
        rd_chk("post_rst_bauddiv", UART_BAUDDIV, 32'd867);
        rd_chk("post_rst_irqen", UART_IRQEN, 32'h0);

        wr(UART_BAUDDIV, 32'h0);
        wr(UART_IRQEN, 32'h1);
        tick();
        check("irq_idle_en", {31'b0, irq}, 32'h1);
        wr(UART_TXDATA, 32'h81);
        tick();
        check("irq_drop_on_pop", {31'b0, irq}, 32'h0);
        k = 1;
        while (!irq && k < 40) begin
            tick();
            k++;
        end
        check("irq_rise_after_pop", k - 1, 11);
        wr(UART_TXDATA, 32'h7E);
        tick();
        check("irq_drop_second_push", {31'b0, irq}, 32'h0);
        k = 0;
        while (!irq && k < 40) begin
            tick();
            k++;
        end
        check("irq_recover", {31'b0, irq}, 32'h1);

        hits = 0;
        adr = BASE + 32'h10; regr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack) hits++;
        end
        regr = 1'b0; wdata = 32'hAA; regw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack || !txd) hits++;
        end
        regw = 1'b0;
        check("out_of_window", hits, 0);
        rd_chk("status_after_oow", UART_STATUS, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
